// File: rtl/f1_pkg.sv
// f1_pkg: race-state encoding and light patterns shared with the starting-light FSM.
package f1_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, SEQ, TIMING, DONE, FAULT} race_state_t;

    // Sliced to LIGHT_WIDTH by users; all lamps lit is the last step before lights-out.
    localparam logic [63:0] LIGHTS_ALL_ON = '1;

endpackage

// File: rtl/react_counter.sv
// react_counter: saturating tick counter with clear, enable and limit compare.
module react_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != LIM)
            count <= count + 1'b1;
    end

    // True when the count is at the limit or will be after this enable.
    assign at_limit = (count == LIM) || (en && count == LIM - 1'b1);

endmodule

// File: rtl/f1_race_controller.sv
// f1_race_controller: race-start sequencer timing driver reaction against the starting lights.
// Optional F1_BEST_TIME_EN adds a best_ms output tracking the fastest clean reaction.
module f1_race_controller
    import f1_pkg::*;
#(
    parameter int LIGHT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT_MS  = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   react,
    input  logic                   tick,
    input  logic [LIGHT_WIDTH-1:0] lights,
    output logic                   seq_trigger,
    output logic [CNT_WIDTH-1:0]   react_ms,
    output logic                   result_valid,
    output logic                   jump_start,
    output logic                   timeout,
    output logic                   busy
`ifdef F1_BEST_TIME_EN
    ,
    output logic [CNT_WIDTH-1:0]   best_ms
`endif
);

    localparam logic [LIGHT_WIDTH-1:0] FULL = LIGHTS_ALL_ON[LIGHT_WIDTH-1:0];

    race_state_t state, state_n;
    logic start_q, react_q, start_edge, react_edge;
    logic full_seen, full_n, jump_n, timeout_n, trig_n;
    logic rc_clr, rc_hit, ac_clr, ac_hit;
    logic [CNT_WIDTH-1:0] arm_ms_unused;

    assign start_edge = start & ~start_q;
    assign react_edge = react & ~react_q;

    react_counter #(.W(CNT_WIDTH), .LIMIT(TIMEOUT_MS)) u_react_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (rc_clr),
        .en       (state == TIMING && tick),
        .count    (react_ms),
        .at_limit (rc_hit)
    );

    react_counter #(.W(CNT_WIDTH), .LIMIT(TIMEOUT_MS)) u_arm_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (ac_clr),
        .en       (state == ARMED && tick),
        .count    (arm_ms_unused),
        .at_limit (ac_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            start_q      <= 1'b1;
            react_q      <= 1'b1;
            seq_trigger  <= 1'b0;
            full_seen    <= 1'b0;
            jump_start   <= 1'b0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            start_q      <= start;
            react_q      <= react;
            seq_trigger  <= trig_n;
            full_seen    <= full_n;
            jump_start   <= jump_n;
            timeout      <= timeout_n;
            result_valid <= state_n inside {DONE, FAULT};
            busy         <= state_n inside {ARMED, SEQ, TIMING};
        end
    end

    always_comb begin
        state_n   = state;
        full_n    = full_seen;
        jump_n    = jump_start;
        timeout_n = timeout;
        trig_n    = 1'b0;
        rc_clr    = 1'b0;
        ac_clr    = 1'b0;
        case (state)
            IDLE, DONE, FAULT: begin
                if (start_edge) begin
                    state_n   = ARMED;
                    full_n    = 1'b0;
                    jump_n    = 1'b0;
                    timeout_n = 1'b0;
                    trig_n    = 1'b1;
                    rc_clr    = 1'b1;
                    ac_clr    = 1'b1;
                end
            end
            ARMED: begin
                if (react_edge) begin
                    state_n = FAULT;
                    jump_n  = 1'b1;
                end else if (lights != '0) begin
                    state_n = SEQ;
                end else if (ac_hit) begin
                    state_n   = FAULT;
                    timeout_n = 1'b1;
                end
            end
            SEQ: begin
                if (react_edge) begin
                    state_n = FAULT;
                    jump_n  = 1'b1;
                end else if (lights == '0) begin
                    // Lights-out without the full pattern is an aborted sequence.
                    state_n = full_seen ? TIMING : IDLE;
                    rc_clr  = full_seen;
                end else if (lights == FULL) begin
                    full_n = 1'b1;
                end
            end
            TIMING: begin
                if (react_edge) begin
                    state_n = DONE;
                end else if (rc_hit) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef F1_BEST_TIME_EN
    localparam logic [CNT_WIDTH-1:0] LIM = CNT_WIDTH'(TIMEOUT_MS);
    logic [CNT_WIDTH-1:0] final_ms;

    // Value react_ms takes at this edge, including a coincident tick.
    assign final_ms = (tick && react_ms != LIM) ? react_ms + 1'b1 : react_ms;

    always_ff @(posedge clk) begin
        if (!rst)
            best_ms <= '1;
        else if (state == TIMING && react_edge && final_ms < best_ms)
            best_ms <= final_ms;
    end
`endif

endmodule
